// File: rtl/speed_sel_ctrl_if.sv
// Button inputs and speed outputs of speed_sel_ctrl, bundled for port connection.
interface speed_sel_ctrl_if;
  logic       btn_up_i;
  logic       btn_dn_i;
  logic [2:0] speed_o;
  logic       speed_chg_o;

  modport master (
    output btn_up_i,
    output btn_dn_i,
    input  speed_o,
    input  speed_chg_o
  );

  modport slave (
    input  btn_up_i,
    input  btn_dn_i,
    output speed_o,
    output speed_chg_o
  );
endinterface

// File: rtl/speed_sel_ctrl.sv
// Up/down push-button speed selector: synchronize, debounce, edge-detect, step a 3-bit code.
// Define SPEED_SEL_WRAP_EN to wrap 7<->0 instead of saturating at the ends.
module speed_sel_ctrl #(
  parameter int unsigned SYNC_FF_STAGE   = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SPEED_RESET     = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  speed_sel_ctrl_if.slave  bus
);

  localparam int unsigned NBTN  = 2;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned SPD_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SPD_W-1:0] SPD_MAX  = '1;
  localparam logic [SPD_W-1:0] SPD_MIN  = '0;

  // Index 0 = up button, index 1 = down button.
  logic [NBTN-1:0]          raw;
  logic [SYNC_FF_STAGE-1:0] sync_q [NBTN];
  logic [CNT_W-1:0]         cnt_q  [NBTN];
  logic [NBTN-1:0]          deb_q;
  logic [NBTN-1:0]          deb_d_q;
  logic [NBTN-1:0]          evt_q;
  logic [SPD_W-1:0]         speed_q;
  logic [SPD_W-1:0]         speed_nxt;
  logic                     chg_q;
  logic                     chg_nxt;

  assign raw = {bus.btn_dn_i, bus.btn_up_i};

  // Synchronizer chains, debounce counters and registered press events.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NBTN); i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      deb_q   <= '0;
      deb_d_q <= '0;
      evt_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++) begin
        sync_q[i] <= {sync_q[i][SYNC_FF_STAGE-2:0], raw[i]};
        if (sync_q[i][SYNC_FF_STAGE-1] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
          deb_q[i] <= ~deb_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      deb_d_q <= deb_q;
      evt_q   <= deb_q & ~deb_d_q;
    end
  end

  // Next speed code; simultaneous up and down events cancel.
  always_comb begin
    speed_nxt = speed_q;
    chg_nxt   = 1'b0;
    case (evt_q)
      2'b01: begin
`ifdef SPEED_SEL_WRAP_EN
        speed_nxt = speed_q + SPD_W'(1);
        chg_nxt   = 1'b1;
`else
        if (speed_q != SPD_MAX) begin
          speed_nxt = speed_q + SPD_W'(1);
          chg_nxt   = 1'b1;
        end
`endif
      end
      2'b10: begin
`ifdef SPEED_SEL_WRAP_EN
        speed_nxt = speed_q - SPD_W'(1);
        chg_nxt   = 1'b1;
`else
        if (speed_q != SPD_MIN) begin
          speed_nxt = speed_q - SPD_W'(1);
          chg_nxt   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      speed_q <= SPD_W'(SPEED_RESET);
      chg_q   <= 1'b0;
    end else begin
      speed_q <= speed_nxt;
      chg_q   <= chg_nxt;
    end
  end

  assign bus.speed_o     = speed_q;
  assign bus.speed_chg_o = chg_q;

endmodule

// File: tb/tb_speed_sel_ctrl.sv
// Directed bench for speed_sel_ctrl: stimulus pushes expected speed changes, a monitor pops and checks them.
module tb_speed_sel_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned LAT  = SYNC + DB + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  speed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_q;
  logic        mon_en;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          chg_cnt = 0;
  logic [2:0]  model_spd;
  logic [2:0]  exp_speed;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  speed_sel_ctrl_if bus_if ();

  speed_sel_ctrl #(
    .SYNC_FF_STAGE   (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .SPEED_RESET     (0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor: every cycle either a reset value, a queued change, or a held value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q === 1'b1) begin
        checks++;
        assert (bus_if.speed_o === 3'd0 && bus_if.speed_chg_o === 1'b0) else begin
          errors++;
          $error("FAIL reset_state speed=%0d chg=%b expected speed=0 chg=0",
                 bus_if.speed_o, bus_if.speed_chg_o);
        end
        exp_speed = 3'd0;
      end else if (bus_if.speed_chg_o === 1'b1) begin
        chg_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_chg cyc=%0d speed=%0d expected no change", cyc, bus_if.speed_o);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          assert (cyc === e.cyc) else begin
            errors++;
            $error("FAIL chg_latency cyc=%0d expected cyc=%0d", cyc, e.cyc);
          end
          checks++;
          assert (bus_if.speed_o === e.speed) else begin
            errors++;
            $error("FAIL chg_value speed=%0d expected %0d", bus_if.speed_o, e.speed);
          end
          exp_speed = e.speed;
        end
      end else begin
        checks++;
        assert (bus_if.speed_o === exp_speed && bus_if.speed_chg_o === 1'b0) else begin
          errors++;
          $error("FAIL hold cyc=%0d speed=%0d chg=%b expected speed=%0d chg=0",
                 cyc, bus_if.speed_o, bus_if.speed_chg_o, exp_speed);
        end
      end
    end
  end

  function automatic logic [2:0] step_speed(input logic [2:0] s, input logic up, input logic dn);
    logic [2:0] r;
    r = s;
`ifdef SPEED_SEL_WRAP_EN
    if (up && !dn) r = s + 3'd1;
    if (dn && !up) r = s - 3'd1;
`else
    if (up && !dn && s != 3'd7) r = s + 3'd1;
    if (dn && !up && s != 3'd0) r = s - 3'd1;
`endif
    return r;
  endfunction

  // Press (and later release) buttons; queue a change only if the code should move.
  task automatic press(input logic up, input logic dn, input int hold, input int gap);
    logic [2:0] nxt;
    bus_if.btn_up_i = up;
    bus_if.btn_dn_i = dn;
    nxt = step_speed(model_spd, up, dn);
    if (nxt != model_spd) begin
      exp_q.push_back('{cyc: cyc + LAT + 1, speed: nxt});
      model_spd = nxt;
    end
    repeat (hold) @(negedge clk);
    bus_if.btn_up_i = 1'b0;
    bus_if.btn_dn_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  initial begin
    int c0;
    mon_en          = 1'b0;
    rst             = 1'b1;
    bus_if.btn_up_i = 1'b0;
    bus_if.btn_dn_i = 1'b0;
    model_spd       = 3'd0;
    exp_speed       = 3'd0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Up held from reset deassertion: one increment after LAT cycles, no repeat.
    c0  = chg_cnt;
    rst = 1'b0;
    press(1'b1, 1'b0, 20, 12);
    check_val("single_press_speed", int'(bus_if.speed_o), 1);
    check_val("single_press_pulses", chg_cnt - c0, 1);
    check_val("single_press_queue", exp_q.size(), 0);

    press(1'b1, 1'b0, 12, 12);
    check_val("second_up", int'(bus_if.speed_o), 2);

    // Down glitch shorter than the debounce window.
    c0 = chg_cnt;
    bus_if.btn_dn_i = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.btn_dn_i = 1'b0;
    repeat (15) @(negedge clk);
    check_val("glitch_speed", int'(bus_if.speed_o), 2);
    check_val("glitch_pulses", chg_cnt - c0, 0);

    press(1'b0, 1'b1, 12, 12);
    check_val("down_press", int'(bus_if.speed_o), 1);
    press(1'b1, 1'b0, 12, 12);
    press(1'b1, 1'b0, 12, 12);
    check_val("up_to_3", int'(bus_if.speed_o), 3);

    // Both buttons on the same edge cancel.
    c0 = chg_cnt;
    press(1'b1, 1'b1, 15, 15);
    check_val("simul_speed", int'(bus_if.speed_o), 3);
    check_val("simul_pulses", chg_cnt - c0, 0);

    // Eight up presses from 0 across the top boundary.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    model_spd = 3'd0;
    c0        = chg_cnt;
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 12, 12);
`ifdef SPEED_SEL_WRAP_EN
    check_val("boundary_up_speed", int'(bus_if.speed_o), 0);
    check_val("boundary_up_pulses", chg_cnt - c0, 8);
`else
    check_val("boundary_up_speed", int'(bus_if.speed_o), 7);
    check_val("boundary_up_pulses", chg_cnt - c0, 7);
`endif
    check_val("boundary_queue", exp_q.size(), 0);

    // Reset one cycle at debounce count 2 with up still held.
    press(1'b1, 1'b0, 0, 0);
    bus_if.btn_up_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    model_spd = 3'd0;
    c0        = chg_cnt;
    exp_q.push_back('{cyc: cyc + LAT + 1, speed: 3'd1});
    model_spd = 3'd1;
    repeat (20) @(negedge clk);
    bus_if.btn_up_i = 1'b0;
    repeat (12) @(negedge clk);
    check_val("rst_mid_speed", int'(bus_if.speed_o), 1);
    check_val("rst_mid_pulses", chg_cnt - c0, 1);

    // Down across the bottom boundary.
    press(1'b0, 1'b1, 12, 12);
    check_val("down_to_0", int'(bus_if.speed_o), 0);
    c0 = chg_cnt;
    press(1'b0, 1'b1, 12, 12);
`ifdef SPEED_SEL_WRAP_EN
    check_val("boundary_dn_speed", int'(bus_if.speed_o), 7);
    check_val("boundary_dn_pulses", chg_cnt - c0, 1);
`else
    check_val("boundary_dn_speed", int'(bus_if.speed_o), 0);
    check_val("boundary_dn_pulses", chg_cnt - c0, 0);
`endif
    check_val("final_queue", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
